// File: rtl/alu_cmd_sequencer_if.sv
// Command channel into alu_cmd_sequencer: one register-transfer command per valid/ready handshake.
interface alu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [3:0]  cmd_srca;
  logic [3:0]  cmd_srcb;
  logic        cmd_use_imm;
  logic [15:0] cmd_imm;
  logic        cmd_wb;
  logic [3:0]  cmd_dst;

  modport master (
    output cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_use_imm, cmd_imm, cmd_wb, cmd_dst,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_use_imm, cmd_imm, cmd_wb, cmd_dst,
    output cmd_ready
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers register-transfer commands in a FIFO and sequences the ALU/register-file datapath
// controls for each one: EXEC drives the datapath, CAPTURE reports the resulting flags.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int NREGS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_cmd_sequencer_if.slave      cmd,
  output logic [7:0]              alu_op,
  output logic [3:0]              a_sel,
  output logic [3:0]              b_sel,
  output logic                    imm_sel,
  output logic [15:0]             imm,
  output logic [NREGS-1:0]        reg_en,
  output logic                    flags_en,
  output logic                    tri_en,
  input  logic [4:0]              flags_in,
  output logic                    done,
  output logic [4:0]              done_flags,
  output logic [3:0]              done_dst,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0]  op;
    logic [3:0]  srca;
    logic [3:0]  srcb;
    logic        use_imm;
    logic [15:0] imm;
    logic        wb;
    logic [3:0]  dst;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, CAPTURE} state_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          push_cmd;
  cmd_t          cmd_q, cmd_d;
  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push, pop, full, empty;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push  = cmd.cmd_valid & ~full;

  assign push_cmd = '{op: cmd.cmd_op, srca: cmd.cmd_srca, srcb: cmd.cmd_srcb,
                      use_imm: cmd.cmd_use_imm, imm: cmd.cmd_imm, wb: cmd.cmd_wb,
                      dst: cmd.cmd_dst};

  assign cmd.cmd_ready = ~full;
  assign busy          = (state_q != IDLE) | ~empty;
  assign fifo_count    = count_q;

  // NOTE: the storage array has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_cmd;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    pop        = 1'b0;
    alu_op     = '0;
    a_sel      = '0;
    b_sel      = '0;
    imm_sel    = 1'b0;
    imm        = '0;
    reg_en     = '0;
    flags_en   = 1'b0;
    tri_en     = 1'b0;
    done       = 1'b0;
    done_flags = '0;
    done_dst   = '0;

    if (state_q != IDLE) begin
      alu_op  = cmd_q.op;
      a_sel   = cmd_q.srca;
      b_sel   = cmd_q.srcb;
      imm_sel = cmd_q.use_imm;
      imm     = cmd_q.use_imm ? cmd_q.imm : '0;
    end

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cmd_d   = mem_q[rd_ptr_q];
          state_d = EXEC;
        end
      end
      EXEC: begin
        tri_en   = 1'b1;
        flags_en = 1'b1;
        if (cmd_q.wb) reg_en = {{(NREGS-1){1'b0}}, 1'b1} << cmd_q.dst;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        done       = 1'b1;
        done_flags = flags_in;
        done_dst   = cmd_q.dst;
        // Loading the next command straight from CAPTURE keeps back-to-back throughput at 2 cycles.
        if (!empty) begin
          pop     = 1'b1;
          cmd_d   = mem_q[rd_ptr_q];
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of accepted-but-unretired commands.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int NREGS = 16;

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  srca;
    logic [3:0]  srcb;
    logic        use_imm;
    logic [15:0] imm;
    logic        wb;
    logic [3:0]  dst;
  } tb_cmd_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [4:0]             flags_in = '0;
  logic [7:0]             alu_op;
  logic [3:0]             a_sel, b_sel;
  logic                   imm_sel;
  logic [15:0]            imm;
  logic [NREGS-1:0]       reg_en;
  logic                   flags_en, tri_en, done, busy;
  logic [4:0]             done_flags;
  logic [3:0]             done_dst;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int failures = 0;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (bus),
    .alu_op     (alu_op),
    .a_sel      (a_sel),
    .b_sel      (b_sel),
    .imm_sel    (imm_sel),
    .imm        (imm),
    .reg_en     (reg_en),
    .flags_en   (flags_en),
    .tri_en     (tri_en),
    .flags_in   (flags_in),
    .done       (done),
    .done_flags (done_flags),
    .done_dst   (done_dst),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: commands accepted but not yet retired, in arrival order.
  tb_cmd_t    exp_q[$];
  tb_cmd_t    pend_cmd;
  bit         pend_push = 1'b0;
  bit         pend_reset = 1'b0;
  bit         prev_exec = 1'b0;
  int         prev_cnt = 0;
  bit         mon_en = 1'b0;
  int         cyc = 0;
  bit         saw_full = 1'b0;
  bit         t4_pending = 1'b0;
  bit         t4_seen = 1'b0;
  bit         flags_fixed = 1'b1;
  logic [3:0] ret_dst[$];
  logic [7:0] ret_op[$];
  int         ret_cyc[$];

  initial forever begin
    @(posedge clk);
    #1;
    if (!flags_fixed) flags_in = 5'($urandom);
  end

  always @(negedge clk) begin
    int      cnt;
    bit      ex, cp;
    tb_cmd_t h;
    cyc++;
    if (pend_reset) begin
      exp_q.delete();
      prev_exec = 1'b0;
      prev_cnt  = 0;
      mon_en    = 1'b1;
    end else if (pend_push) begin
      exp_q.push_back(pend_cmd);
    end
    cnt = 0;
    if (mon_en) begin
      // A command starts executing the cycle after one is waiting while not already executing.
      ex  = !prev_exec && prev_cnt > 0;
      cp  = prev_exec;
      cnt = exp_q.size() - ((ex || cp) ? 1 : 0);
      h   = '{default: '0};
      if (exp_q.size() != 0) h = exp_q[0];
      check("m_tri_en", 32'(tri_en), 32'(ex));
      check("m_flags_en", 32'(flags_en), 32'(ex));
      check("m_done", 32'(done), 32'(cp));
      check("m_fifo_count", 32'(fifo_count), 32'(cnt));
      check("m_cmd_ready", 32'(bus.cmd_ready), 32'(cnt != DEPTH));
      check("m_busy", 32'(busy), 32'(exp_q.size() != 0));
      check("m_reg_en_onehot0", 32'($onehot0(reg_en)), 32'd1);
      if (ex || cp) begin
        check("m_cmd_available", 32'(exp_q.size() != 0), 32'd1);
        check("m_alu_op", 32'(alu_op), 32'(h.op));
        check("m_a_sel", 32'(a_sel), 32'(h.srca));
        check("m_b_sel", 32'(b_sel), 32'(h.srcb));
      end else begin
        check("m_idle_alu_op", 32'(alu_op), 32'd0);
        check("m_idle_sel", 32'({a_sel, b_sel, imm_sel}), 32'd0);
        check("m_idle_imm", 32'(imm), 32'd0);
        check("m_idle_reg_en", 32'(reg_en), 32'd0);
      end
      if (ex) begin
        check("m_imm_sel", 32'(imm_sel), 32'(h.use_imm));
        check("m_imm", 32'(imm), h.use_imm ? 32'(h.imm) : 32'd0);
        check("m_reg_en", 32'(reg_en), h.wb ? (32'd1 << h.dst) : 32'd0);
      end
      if (cp) begin
        check("m_cap_reg_en", 32'(reg_en), 32'd0);
        check("m_done_dst", 32'(done_dst), 32'(h.dst));
        check("m_done_flags", 32'(done_flags), 32'(flags_in));
        ret_dst.push_back(done_dst);
        ret_op.push_back(alu_op);
        ret_cyc.push_back(cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        check("m_done_dst_zero", 32'(done_dst), 32'd0);
        check("m_done_flags_zero", 32'(done_flags), 32'd0);
      end
      if (t4_pending) begin
        check("t4_count_held", 32'(fifo_count), 32'd2);
        check("t4_next_exec", 32'(tri_en), 32'd1);
        t4_seen = 1'b1;
      end
      t4_pending = cp && cnt == 2 && bus.cmd_valid && !reset;
      if (cnt == DEPTH) saw_full = 1'b1;
      prev_exec = ex;
      prev_cnt  = cnt;
    end
    pend_push = mon_en && bus.cmd_valid && (cnt != DEPTH) && !reset;
    pend_reset = reset;
    pend_cmd = '{op: bus.cmd_op, srca: bus.cmd_srca, srcb: bus.cmd_srcb, use_imm: bus.cmd_use_imm,
                 imm: bus.cmd_imm, wb: bus.cmd_wb, dst: bus.cmd_dst};
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input tb_cmd_t c);
    bit acc;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = c.op;
    bus.cmd_srca    = c.srca;
    bus.cmd_srcb    = c.srcb;
    bus.cmd_use_imm = c.use_imm;
    bus.cmd_imm     = c.imm;
    bus.cmd_wb      = c.wb;
    bus.cmd_dst     = c.dst;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      sync();
    end
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  function automatic tb_cmd_t rand_cmd(input logic [3:0] dst, input logic wb);
    tb_cmd_t c;
    c.op      = 8'($urandom);
    c.srca    = 4'($urandom);
    c.srcb    = 4'($urandom);
    c.use_imm = 1'($urandom);
    c.imm     = 16'($urandom);
    c.wb      = wb;
    c.dst     = dst;
    return c;
  endfunction

  initial begin
    tb_cmd_t    c;
    logic [3:0] sent_dst[$];
    logic [7:0] sent_op[$];
    int         n;

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_srca = '0; bus.cmd_srcb = '0;
    bus.cmd_use_imm = 1'b0; bus.cmd_imm = '0; bus.cmd_wb = 1'b0; bus.cmd_dst = '0;

    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_outputs", 32'({done, tri_en, flags_en, reg_en}), 32'd0);

    // Single write-back command with fixed flags.
    flags_in = 5'b00100;
    c = '{op: 8'h01, srca: 4'd2, srcb: 4'd3, use_imm: 1'b0, imm: 16'h0, wb: 1'b1, dst: 4'd5};
    send(c);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("t1_not_yet_exec", 32'(tri_en), 32'd0);
    check("t1_queued", 32'(fifo_count), 32'd1);
    @(negedge clk);
    check("t1_exec_tri_en", 32'(tri_en), 32'd1);
    check("t1_exec_flags_en", 32'(flags_en), 32'd1);
    check("t1_exec_a_sel", 32'(a_sel), 32'd2);
    check("t1_exec_b_sel", 32'(b_sel), 32'd3);
    check("t1_exec_reg_en", 32'(reg_en), 32'h0020);
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_done_dst", 32'(done_dst), 32'd5);
    check("t1_done_flags", 32'(done_flags), 32'b00100);
    @(negedge clk);
    check("t1_done_pulse_end", 32'(done), 32'd0);

    // Immediate compare, flags only.
    sync();
    c = '{op: 8'h22, srca: 4'd7, srcb: 4'd1, use_imm: 1'b1, imm: 16'hBEEF, wb: 1'b0, dst: 4'd9};
    send(c);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t2_imm_sel", 32'(imm_sel), 32'd1);
    check("t2_imm", 32'(imm), 32'hBEEF);
    check("t2_reg_en", 32'(reg_en), 32'd0);
    check("t2_flags_en", 32'(flags_en), 32'd1);
    @(negedge clk);
    check("t2_done", 32'(done), 32'd1);
    check("t2_done_dst", 32'(done_dst), 32'd9);
    flags_fixed = 1'b0;

    // Burst with cmd_valid held: fills the FIFO and streams back-to-back.
    sync();
    ret_dst.delete(); ret_op.delete(); ret_cyc.delete();
    saw_full = 1'b0;
    for (int i = 1; i <= 10; i++) send(rand_cmd(4'(i), 1'b1));
    bus.cmd_valid = 1'b0;
    wait_idle(200);
    check("t3_retired", 32'(ret_dst.size()), 32'd10);
    for (int i = 0; i < ret_dst.size(); i++) begin
      check("t3_order", 32'(ret_dst[i]), 32'(i + 1));
      if (i > 0) check("t3_spacing", 32'(ret_cyc[i] - ret_cyc[i-1]), 32'd2);
    end
    check("t3_reached_full", 32'(saw_full), 32'd1);
    check("t4_push_pop_seen", 32'(t4_seen), 32'd1);

    // Reset during EXEC abandons the command.
    sync();
    n = ret_dst.size();
    send('{op: 8'h33, srca: 4'd1, srcb: 4'd2, use_imm: 1'b0, imm: 16'h0, wb: 1'b1, dst: 4'd7});
    bus.cmd_valid = 1'b0;
    sync();
    reset = 1'b1;
    @(negedge clk);
    check("t5_in_exec", 32'(tri_en), 32'd1);
    sync();
    reset = 1'b0;
    check("t5_reg_en", 32'(reg_en), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_fifo_count", 32'(fifo_count), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("t5_no_done", 32'(ret_dst.size()), 32'(n));

    // Pointer wrap with gaps, then longer random traffic with mixed write-back.
    for (int pass = 0; pass < 2; pass++) begin
      sync();
      ret_dst.delete(); ret_op.delete(); ret_cyc.delete();
      sent_dst.delete(); sent_op.delete();
      for (int i = 0; i < (pass == 0 ? 10 : 40); i++) begin
        c = rand_cmd(4'($urandom), pass == 0 ? 1'b1 : 1'($urandom));
        sent_dst.push_back(c.dst);
        sent_op.push_back(c.op);
        send(c);
        bus.cmd_valid = 1'b0;
        repeat ($urandom_range(0, 3)) sync();
        bus.cmd_valid = 1'b0;
      end
      wait_idle(300);
      check("t6_retired", 32'(ret_dst.size()), 32'(sent_dst.size()));
      for (int i = 0; i < ret_dst.size() && i < sent_dst.size(); i++) begin
        check("t6_dst", 32'(ret_dst[i]), 32'(sent_dst[i]));
        check("t6_op", 32'(ret_op[i]), 32'(sent_op[i]));
      end
      check("t6_fifo_empty", 32'(fifo_count), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
